// File: rtl/shreg_seq_ctrl.sv
// shreg_seq_ctrl: command sequencer for a 4-bit universal shift register.
// On i_start it captures a word and shift count, then parallel-loads the
// register. It then issues the requested number of left or right shifts and
// streams each outgoing bit on o_sout. Completion is flagged by o_done.
// Optional feature macro: SHREG_SEQ_CTRL_ROTATE_EN. When it is defined, a
// captured rotate request feeds the outgoing bit back in as the inserted bit.
module shreg_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic             i_fill,
    input  logic             i_rot,
    input  logic [WIDTH-1:0] i_par,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_Q,
    output logic [1:0]       o_sel,
    output logic [WIDTH-1:0] o_par,
    output logic             o_il,
    output logic             o_id,
    output logic             o_sout,
    output logic             o_sout_vld,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] par_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             fill_q;
    logic             rot_q;
    logic             rot_en;

`ifdef SHREG_SEQ_CTRL_ROTATE_EN
    assign rot_en = rot_q;
`else
    logic unused_rot;
    assign rot_en     = 1'b0;
    assign unused_rot = rot_q;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture the command in IDLE; count down the remaining shifts in SHIFT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
            rot_q  <= 1'b0;
        end else if (state == S_IDLE && i_start) begin
            par_q  <= i_par;
            cnt_q  <= i_cnt;
            dir_q  <= i_dir;
            fill_q <= i_fill;
            rot_q  <= i_rot;
        end else if (state == S_SHIFT) begin
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    // Next-state and Moore output decode from state and the captured command.
    always_comb begin
        state_nx   = state;
        o_sel      = 2'b00;
        o_par      = '0;
        o_il       = 1'b0;
        o_id       = 1'b0;
        o_sout     = 1'b0;
        o_sout_vld = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                o_sel    = 2'b01;
                o_par    = par_q;
                o_busy   = 1'b1;
                state_nx = (cnt_q != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                o_sel      = dir_q ? 2'b11 : 2'b10;
                o_busy     = 1'b1;
                o_sout_vld = 1'b1;
                o_sout     = dir_q ? i_Q[0] : i_Q[WIDTH-1];
                if (dir_q) begin
                    o_il = rot_en ? i_Q[0] : fill_q;
                end else begin
                    o_id = rot_en ? i_Q[WIDTH-1] : fill_q;
                end
                // cnt_q still holds the pre-decrement value here; the last
                // shift is the one that sees 1.
                if (cnt_q <= CNT_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Testbench for shreg_seq_ctrl: directed and random commands against an
// arithmetic reference model, with a behavioural 4-bit shift register as plant.
// Honours SHREG_SEQ_CTRL_ROTATE_EN to select the expected rotate behaviour.
module tb_shreg_seq_ctrl;

`ifdef SHREG_SEQ_CTRL_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_dir;
    logic       i_fill;
    logic       i_rot;
    logic [3:0] i_par;
    logic [2:0] i_cnt;
    logic [3:0] i_Q;
    logic [1:0] o_sel;
    logic [3:0] o_par;
    logic       o_il;
    logic       o_id;
    logic       o_sout;
    logic       o_sout_vld;
    logic       o_busy;
    logic       o_done;

    logic [3:0] q = 4'b0110;
    int         checks = 0;
    int         errors = 0;

    shreg_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_dir      (i_dir),
        .i_fill     (i_fill),
        .i_rot      (i_rot),
        .i_par      (i_par),
        .i_cnt      (i_cnt),
        .i_Q        (i_Q),
        .o_sel      (o_sel),
        .o_par      (o_par),
        .o_il       (o_il),
        .o_id       (o_id),
        .o_sout     (o_sout),
        .o_sout_vld (o_sout_vld),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Plant: the universal shift register driven by the controller.
    always @(posedge i_clk) begin
        case (o_sel)
            2'b01:   q <= o_par;
            2'b10:   q <= {q[2:0], o_id};
            2'b11:   q <= {o_il, q[3:1]};
            default: q <= q;
        endcase
    end
    assign i_Q = q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Runs one command starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic run_cmd(input logic [3:0] par, input logic [2:0] cnt, input logic dir,
                           input logic fill, input logic rot, input bit poke, input bit keep);
        int v;
        int out;
        int ins;
        check("idle_busy", o_busy, 0);
        check("idle_sel", o_sel, 0);
        i_par = par; i_cnt = cnt; i_dir = dir; i_fill = fill; i_rot = rot;
        i_start = 1'b1;
        tick();
        if (!keep) i_start = 1'b0;
        i_par = ~par; i_cnt = ~cnt; i_dir = ~dir; i_fill = ~fill; i_rot = ~rot;
        check("load_sel", o_sel, 1);
        check("load_par", o_par, par);
        check("load_busy", o_busy, 1);
        check("load_vld", o_sout_vld, 0);
        check("load_done", o_done, 0);
        v = par;
        for (int k = 0; k < cnt; k++) begin
            tick();
            if (poke && k == 0) i_start = 1'b1;
            if (poke && k == 1) i_start = 1'b0;
            out = dir ? (v & 1) : ((v >> 3) & 1);
            ins = (rot && ROT) ? out : fill;
            check("sh_sel", o_sel, dir ? 3 : 2);
            check("sh_vld", o_sout_vld, 1);
            check("sh_sout", o_sout, out);
            check("sh_id", o_id, dir ? 0 : ins);
            check("sh_il", o_il, dir ? ins : 0);
            check("sh_busy", o_busy, 1);
            check("sh_done", o_done, 0);
            v = dir ? ((ins << 3) | (v >> 1)) : (((v << 1) | ins) & 15);
        end
        tick();
        if (poke) i_start = 1'b0;
        check("done_pulse", o_done, 1);
        check("done_sel", o_sel, 0);
        check("done_busy", o_busy, 1);
        check("done_vld", o_sout_vld, 0);
        check("done_par", o_par, 0);
        check("final_q", q, v);
        tick();
        check("post_busy", o_busy, 0);
        check("post_done", o_done, 0);
        check("post_sel", o_sel, 0);
    endtask

    initial begin
        logic [3:0] qsave;
        i_rst_n = 1'b0; i_start = 1'b0; i_dir = 1'b0; i_fill = 1'b0; i_rot = 1'b0;
        i_par = '0; i_cnt = '0;
        tick();
        tick();
        check("rst_sel", o_sel, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_q_held", q, 4'b0110);
        i_rst_n = 1'b1;
        tick();

        run_cmd(4'b1011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(4'b0110, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cmd(4'b0101, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cmd(4'b1001, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cmd(4'b1110, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cmd(4'b0011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cmd(4'b0001, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cmd(4'b1000, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a shift sequence.
        i_par = 4'b1010; i_cnt = 3'd5; i_dir = 1'b0; i_fill = 1'b1; i_rot = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        check("pre_rst_vld", o_sout_vld, 1);
        #2 i_rst_n = 1'b0;
        #1;
        qsave = q;
        check("arst_sel", o_sel, 0);
        check("arst_busy", o_busy, 0);
        check("arst_vld", o_sout_vld, 0);
        check("arst_sout", o_sout, 0);
        check("arst_ilid", {o_il, o_id}, 0);
        check("arst_par", o_par, 0);
        check("arst_done", o_done, 0);
        tick();
        check("arst_q_held", q, qsave);
        check("arst_done2", o_done, 0);
        i_rst_n = 1'b1;
        tick();
        check("arst_idle_busy", o_busy, 0);
        check("arst_idle_done", o_done, 0);

        for (int i = 0; i < 20; i++) begin
            run_cmd(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'b0, (i < 19) ? 1'($urandom) : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
